// File: rtl/exc_collect.sv
// Memory-stage exception collector and E->M register feeding CP0; outputs are presented one cycle after E capture.
// Optional data-alignment checking is compiled in with EXC_ALIGN_CHECK_EN; stalled instructions fire their side effects once.
module exc_collect #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        valid_e,
  input  logic [31:0] pc_e,
  input  logic        ri_e,
  input  logic        sys_e,
  input  logic        bp_e,
  input  logic        eret_e,
  input  logic        ov_e,
  input  logic        mtc0_e,
  input  logic        branch_e,
  input  logic [4:0]  cp0_wa_e,
  input  logic [31:0] cp0_wdata_e,
  input  logic        mem_ld_e,
  input  logic        mem_st_e,
  input  logic [1:0]  mem_size_e,
  input  logic [31:0] mem_addr_e,
  output logic [11:0] error,
  output logic [31:0] BadVaddr,
  output logic [31:0] pcM,
  output logic [4:0]  wa,
  output logic [31:0] cp_wdata,
  output logic        mem_kill
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FRESH = 2'd1,
    SPENT = 2'd2
  } state_t;

  state_t      state_q;
  logic        in_slot_q;
  logic [11:0] m_err_q;
  logic [31:0] m_pc_q;
  logic [31:0] m_bad_q;
  logic [4:0]  m_wa_q;
  logic [31:0] m_wdata_q;

  logic        fetch_err;
  logic        adel;
  logic        ades;
  logic [11:0] err_d;
  logic [31:0] bad_d;
  logic [11:0] err_w;

  assign fetch_err = |pc_e[1:0];

`ifdef EXC_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = ((mem_size_e == 2'd1) && mem_addr_e[0]) ||
                      ((mem_size_e == 2'd2) && (|mem_addr_e[1:0]));
  assign adel = mem_ld_e && misaligned;
  assign ades = mem_st_e && misaligned;
`else
  logic unused_align;
  assign unused_align = ^{mem_ld_e, mem_st_e, mem_size_e, mem_addr_e};
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

  assign err_d = {mtc0_e, 2'b00, in_slot_q, ov_e, fetch_err, adel, ades,
                  eret_e, bp_e, sys_e, ri_e};
  assign bad_d = fetch_err     ? pc_e :
                 (adel || ades) ? mem_addr_e : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= EMPTY;
      in_slot_q <= 1'b0;
      m_err_q   <= '0;
      m_pc_q    <= RESET_PC;
      m_bad_q   <= '0;
      m_wa_q    <= '0;
      m_wdata_q <= '0;
    end else if (flush_i) begin
      state_q   <= EMPTY;
      in_slot_q <= 1'b0;
    end else if (!stall_i) begin
      if (valid_e) begin
        state_q   <= FRESH;
        in_slot_q <= branch_e;
        m_err_q   <= err_d;
        m_pc_q    <= pc_e;
        m_bad_q   <= bad_d;
        m_wa_q    <= cp0_wa_e;
        m_wdata_q <= cp0_wdata_e;
      end else begin
        // m_pc_q is kept so a bubble still reports the last real PC.
        state_q <= EMPTY;
      end
    end else if (state_q == FRESH) begin
      state_q <= SPENT;
    end
  end

  always_comb begin
    err_w    = '0;
    BadVaddr = '0;
    pcM      = m_pc_q;
    cp_wdata = '0;
    case (state_q)
      FRESH: begin
        err_w    = m_err_q;
        BadVaddr = m_bad_q;
        cp_wdata = m_wdata_q;
      end
      SPENT: begin
        // Only the delay-slot flag survives so side effects act once.
        err_w    = m_err_q & 12'h100;
        BadVaddr = m_bad_q;
        cp_wdata = m_wdata_q;
      end
      default: begin
        err_w[8] = in_slot_q;
        pcM      = valid_e ? pc_e : m_pc_q;
      end
    endcase
  end

  assign error    = err_w;
  assign wa       = err_w[11] ? m_wa_q : 5'd0;
  assign mem_kill = (|err_w[7:0]) || flush_i || (state_q == EMPTY);

endmodule

// File: tb/tb_exc_collect.sv
// Directed bench for exc_collect: stimulus pushes expected CP0-facing outputs, a negedge monitor pops and compares.
module tb_exc_collect;

`ifdef EXC_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic        ri, sys, bp, eret, ov, mtc0, br;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ld, st;
    logic [1:0]  sz;
    logic [31:0] addr;
  } ein_t;

  typedef struct {
    int          id;
    logic [11:0] err;
    logic [31:0] bad;
    logic [31:0] pc;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        kill;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  ein_t        cur;
  logic [11:0] error;
  logic [31:0] BadVaddr, pcM, cp_wdata;
  logic [4:0]  wa;
  logic        mem_kill;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exc_collect dut (
    .clk(clk), .resetn(resetn), .stall_i(stall), .flush_i(flush),
    .valid_e(cur.v), .pc_e(cur.pc), .ri_e(cur.ri), .sys_e(cur.sys),
    .bp_e(cur.bp), .eret_e(cur.eret), .ov_e(cur.ov), .mtc0_e(cur.mtc0),
    .branch_e(cur.br), .cp0_wa_e(cur.wa), .cp0_wdata_e(cur.wd),
    .mem_ld_e(cur.ld), .mem_st_e(cur.st), .mem_size_e(cur.sz),
    .mem_addr_e(cur.addr), .error(error), .BadVaddr(BadVaddr), .pcM(pcM),
    .wa(wa), .cp_wdata(cp_wdata), .mem_kill(mem_kill)
  );

  function automatic ein_t nop();
    ein_t e;
    e = '{v:1'b0, pc:32'h0, ri:1'b0, sys:1'b0, bp:1'b0, eret:1'b0, ov:1'b0,
          mtc0:1'b0, br:1'b0, wa:5'd0, wd:32'h0, ld:1'b0, st:1'b0, sz:2'd0,
          addr:32'h0};
    return e;
  endfunction

  function automatic ein_t ins(input logic [31:0] pc);
    ein_t e;
    e    = nop();
    e.v  = 1'b1;
    e.pc = pc;
    return e;
  endfunction

  function automatic exp_t mk(input int id, input logic [11:0] err,
                              input logic [31:0] bad, input logic [31:0] pc,
                              input logic [4:0] w, input logic [31:0] wd,
                              input logic kill);
    exp_t x;
    x = '{id:id, err:err, bad:bad, pc:pc, wa:w, wd:wd, kill:kill};
    return x;
  endfunction

  task automatic cyc(input ein_t e, input logic st, input logic fl, input exp_t x);
    @(posedge clk);
    #1;
    cur   = e;
    stall = st;
    flush = fl;
    expq.push_back(x);
  endtask

  task automatic cmp(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step%0d actual=%h required=%h", nm, id, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      exp_t x;
      x = expq.pop_front();
      cmp("error",    x.id, {20'h0, error},    {20'h0, x.err});
      cmp("BadVaddr", x.id, BadVaddr,          x.bad);
      cmp("pcM",      x.id, pcM,               x.pc);
      cmp("wa",       x.id, {27'h0, wa},       {27'h0, x.wa});
      cmp("cp_wdata", x.id, cp_wdata,          x.wd);
      cmp("mem_kill", x.id, {31'h0, mem_kill}, {31'h0, x.kill});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ein_t e;
    cur = nop();

    // reset state
    cyc(nop(), 1'b0, 1'b0, mk(0, 12'h000, 32'h0, 32'hbfc00000, 5'd0, 32'h0, 1'b1));
    @(negedge clk);
    #1 resetn = 1'b1;

    // misaligned word load
    e = ins(32'h80001000); e.ld = 1'b1; e.sz = 2'd2; e.addr = 32'h80000002;
    cyc(e, 1'b0, 1'b0, mk(1, 12'h000, 32'h0, 32'h80001000, 5'd0, 32'h0, 1'b1));
    cyc(nop(), 1'b0, 1'b0, mk(2, ALN ? 12'h020 : 12'h000,
        ALN ? 32'h80000002 : 32'h0, 32'h80001000, 5'd0, 32'h0, ALN));

    // branch then MTC0 in the delay slot
    e = ins(32'hbfc00010); e.br = 1'b1;
    cyc(e, 1'b0, 1'b0, mk(3, 12'h000, 32'h0, 32'hbfc00010, 5'd0, 32'h0, 1'b1));
    e = ins(32'hbfc00014); e.mtc0 = 1'b1; e.wa = 5'd12; e.wd = 32'h0000ff01;
    cyc(e, 1'b0, 1'b0, mk(4, 12'h000, 32'h0, 32'hbfc00010, 5'd0, 32'h0, 1'b0));
    cyc(nop(), 1'b0, 1'b0, mk(5, 12'h900, 32'h0, 32'hbfc00014, 5'd12, 32'h0000ff01, 1'b0));
    cyc(nop(), 1'b0, 1'b0, mk(6, 12'h000, 32'h0, 32'hbfc00014, 5'd0, 32'h0, 1'b1));

    // MTC0 held by a three-cycle stall
    e = ins(32'hbfc00018); e.mtc0 = 1'b1; e.wa = 5'd14; e.wd = 32'h12345678;
    cyc(e, 1'b0, 1'b0, mk(7, 12'h000, 32'h0, 32'hbfc00018, 5'd0, 32'h0, 1'b1));
    e = ins(32'hbfc0001c); e.br = 1'b1;
    cyc(e, 1'b1, 1'b0, mk(8,  12'h800, 32'h0, 32'hbfc00018, 5'd14, 32'h12345678, 1'b0));
    cyc(e, 1'b1, 1'b0, mk(9,  12'h000, 32'h0, 32'hbfc00018, 5'd0,  32'h12345678, 1'b0));
    cyc(e, 1'b1, 1'b0, mk(10, 12'h000, 32'h0, 32'hbfc00018, 5'd0,  32'h12345678, 1'b0));
    cyc(e, 1'b0, 1'b0, mk(11, 12'h000, 32'h0, 32'hbfc00018, 5'd0,  32'h12345678, 1'b0));

    // flush together with stall discards the valid E instruction
    e = ins(32'hbfc00020); e.ov = 1'b1;
    cyc(e, 1'b1, 1'b1, mk(12, 12'h000, 32'h0, 32'hbfc0001c, 5'd0, 32'h0, 1'b1));
    cyc(nop(), 1'b0, 1'b0, mk(13, 12'h000, 32'h0, 32'hbfc0001c, 5'd0, 32'h0, 1'b1));

    // misaligned fetch plus misaligned store
    e = ins(32'hbfc00001); e.st = 1'b1; e.sz = 2'd2; e.addr = 32'h80000006;
    cyc(e, 1'b0, 1'b0, mk(14, 12'h000, 32'h0, 32'hbfc00001, 5'd0, 32'h0, 1'b1));
    cyc(nop(), 1'b0, 1'b0, mk(15, ALN ? 12'h050 : 12'h040,
        32'hbfc00001, 32'hbfc00001, 5'd0, 32'h0, 1'b1));

    // half load misaligned, byte store, RI+Ov
    e = ins(32'hbfc00024); e.ld = 1'b1; e.sz = 2'd1; e.addr = 32'h80000011;
    cyc(e, 1'b0, 1'b0, mk(16, 12'h000, 32'h0, 32'hbfc00024, 5'd0, 32'h0, 1'b1));
    e = ins(32'hbfc00028); e.st = 1'b1; e.sz = 2'd0; e.addr = 32'h80000003;
    cyc(e, 1'b0, 1'b0, mk(17, ALN ? 12'h020 : 12'h000,
        ALN ? 32'h80000011 : 32'h0, 32'hbfc00024, 5'd0, 32'h0, ALN));
    e = ins(32'hbfc0002c); e.st = 1'b1; e.sz = 2'd2; e.addr = 32'h80000004;
    e.ov = 1'b1; e.ri = 1'b1;
    cyc(e, 1'b0, 1'b0, mk(18, 12'h000, 32'h0, 32'hbfc00028, 5'd0, 32'h0, 1'b0));
    cyc(nop(), 1'b0, 1'b0, mk(19, 12'h081, 32'h0, 32'hbfc0002c, 5'd0, 32'h0, 1'b1));

    // slot tracking across bubbles and back-to-back branches
    e = ins(32'hbfc00030); e.br = 1'b1;
    cyc(e, 1'b0, 1'b0, mk(20, 12'h000, 32'h0, 32'hbfc00030, 5'd0, 32'h0, 1'b1));
    cyc(nop(), 1'b0, 1'b0, mk(21, 12'h000, 32'h0, 32'hbfc00030, 5'd0, 32'h0, 1'b0));
    cyc(nop(), 1'b0, 1'b0, mk(22, 12'h100, 32'h0, 32'hbfc00030, 5'd0, 32'h0, 1'b1));
    e = ins(32'hbfc00034); e.br = 1'b1;
    cyc(e, 1'b0, 1'b0, mk(23, 12'h100, 32'h0, 32'hbfc00034, 5'd0, 32'h0, 1'b1));
    e = ins(32'hbfc00038); e.eret = 1'b1;
    cyc(e, 1'b0, 1'b0, mk(24, 12'h100, 32'h0, 32'hbfc00034, 5'd0, 32'h0, 1'b0));
    cyc(nop(), 1'b1, 1'b0, mk(25, 12'h108, 32'h0, 32'hbfc00038, 5'd0, 32'h0, 1'b1));
    cyc(nop(), 1'b1, 1'b0, mk(26, 12'h100, 32'h0, 32'hbfc00038, 5'd0, 32'h0, 1'b0));

    // asynchronous reset in the middle of a stall
    cyc(nop(), 1'b1, 1'b0, mk(27, 12'h000, 32'h0, 32'hbfc00000, 5'd0, 32'h0, 1'b1));
    #1 resetn = 1'b0;

    repeat (3) @(posedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
